// File: rtl/rvfi_retire_monitor.sv
// rvfi_retire_monitor: checks an RVFI retirement stream for self-consistency, latching the first violation
module rvfi_retire_monitor #(
   parameter int XLEN       = 32,
   parameter int C_EXT      = 0,
   parameter int CHECK_REGS = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_rvfi_valid,
   input  logic [63:0]     i_rvfi_order,
   input  logic [31:0]     i_rvfi_insn,
   input  logic            i_rvfi_trap,
   input  logic            i_rvfi_halt,
   input  logic            i_rvfi_intr,
   input  logic [4:0]      i_rvfi_rs1_addr,
   input  logic [4:0]      i_rvfi_rs2_addr,
   input  logic [XLEN-1:0] i_rvfi_rs1_rdata,
   input  logic [XLEN-1:0] i_rvfi_rs2_rdata,
   input  logic [4:0]      i_rvfi_rd_addr,
   input  logic [XLEN-1:0] i_rvfi_rd_wdata,
   input  logic [XLEN-1:0] i_rvfi_pc_rdata,
   input  logic [XLEN-1:0] i_rvfi_pc_wdata,
   output logic            o_err,
   output logic [2:0]      o_err_code,
   output logic [63:0]     o_err_order,
   output logic [31:0]     o_retired,
   output logic            o_halted
);
   logic            err_q, err_d, halted_q, halted_d, pc_known_q, pc_known_d;
   logic [2:0]      code_q, code_d;
   logic [63:0]     err_order_q, err_order_d, exp_order_q, exp_order_d;
   logic [31:0]     retired_q, retired_d;
   logic [XLEN-1:0] exp_pc_q, exp_pc_d;
   logic [31:1]     valid_q, valid_d;
   logic [XLEN-1:0] shadow_q [32];
   logic [31:0]     vld;
   logic            rs1_bad, rs2_bad, align_bad, chk, pass;
   logic [2:0]      code_c;
   logic            unused_insn;

   assign unused_insn = ^i_rvfi_insn;
   assign vld = {valid_q, 1'b0};

   // evaluate all checks against pre-update state, lowest code wins
   always_comb begin
      rs1_bad   = (CHECK_REGS != 0) && ((i_rvfi_rs1_addr == 5'd0) ? (i_rvfi_rs1_rdata != '0)
                  : (vld[i_rvfi_rs1_addr] && i_rvfi_rs1_rdata != shadow_q[i_rvfi_rs1_addr]));
      rs2_bad   = (CHECK_REGS != 0) && ((i_rvfi_rs2_addr == 5'd0) ? (i_rvfi_rs2_rdata != '0)
                  : (vld[i_rvfi_rs2_addr] && i_rvfi_rs2_rdata != shadow_q[i_rvfi_rs2_addr]));
      align_bad = !i_rvfi_trap && ((C_EXT != 0) ? i_rvfi_pc_wdata[0] : (i_rvfi_pc_wdata[1:0] != 2'b00));
      code_c    = (i_rvfi_order != exp_order_q)                              ? 3'd1 :
                  (pc_known_q && !i_rvfi_intr && i_rvfi_pc_rdata != exp_pc_q) ? 3'd2 :
                  (i_rvfi_rd_addr == 5'd0 && i_rvfi_rd_wdata != '0)            ? 3'd3 :
                  rs1_bad                                                    ? 3'd4 :
                  rs2_bad                                                    ? 3'd5 :
                  align_bad                                                  ? 3'd6 :
                  halted_q                                                   ? 3'd7 : 3'd0;
      chk  = i_rvfi_valid && !err_q;
      pass = chk && code_c == 3'd0;
   end

   // next-state: latch the first failure, otherwise advance the stream model on a passing retire
   always_comb begin
      err_d       = err_q;
      code_d      = code_q;
      err_order_d = err_order_q;
      retired_d   = retired_q;
      halted_d    = halted_q;
      exp_order_d = exp_order_q;
      exp_pc_d    = exp_pc_q;
      pc_known_d  = pc_known_q;
      valid_d     = valid_q;
      if (chk && !pass) begin
         err_d       = 1'b1;
         code_d      = code_c;
         err_order_d = i_rvfi_order;
      end else if (pass) begin
         exp_order_d = i_rvfi_order + 64'd1;
         exp_pc_d    = i_rvfi_pc_wdata;
         pc_known_d  = 1'b1;
         retired_d   = retired_q + 32'd1;
         halted_d    = halted_q | i_rvfi_halt;
         if (i_rvfi_rd_addr != 5'd0) valid_d[i_rvfi_rd_addr] = 1'b1;
      end
   end

   // monitor state register, cleared asynchronously
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_q       <= 1'b0;
         code_q      <= 3'd0;
         err_order_q <= 64'd0;
         retired_q   <= 32'd0;
         halted_q    <= 1'b0;
         exp_order_q <= 64'd0;
         exp_pc_q    <= '0;
         pc_known_q  <= 1'b0;
         valid_q     <= '0;
      end else begin
         err_q       <= err_d;
         code_q      <= code_d;
         err_order_q <= err_order_d;
         retired_q   <= retired_d;
         halted_q    <= halted_d;
         exp_order_q <= exp_order_d;
         exp_pc_q    <= exp_pc_d;
         pc_known_q  <= pc_known_d;
         valid_q     <= valid_d;
      end
   end

   // shadow register data, qualified by valid_q so it needs no reset
   always_ff @(posedge i_clk) begin
      if (pass && i_rvfi_rd_addr != 5'd0) shadow_q[i_rvfi_rd_addr] <= i_rvfi_rd_wdata;
   end

   assign o_err       = err_q;
   assign o_err_code  = code_q;
   assign o_err_order = err_order_q;
   assign o_retired   = retired_q;
   assign o_halted    = halted_q;
endmodule

// File: doc/rvfi_retire_monitor.md
Name: rvfi_retire_monitor

Overview:
- Consumer end of the RVFI retirement interface driven by discrete_core.
- Sits beside the core in simulation and formal harnesses and checks the retired-instruction stream for self-consistency:
  - order sequence
  - PC continuity
  - x0 invariance
  - source-operand agreement with a shadow register file
  - alignment of the next PC
- Reports the first violation as a sticky error with a code and the offending order number.

Parameters:
XLEN, 32, register/PC width
C_EXT, 0, 1 = compressed allowed (next PC checked at 2-byte alignment), 0 = 4-byte
CHECK_REGS, 1, 1 = shadow register file and rs1/rs2 checks enabled, 0 = checks 4/5 disabled

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_rvfi_valid  in  1  one instruction retires this cycle (NRET=1)
i_rvfi_order  in  64  retirement index
i_rvfi_insn  in  32  instruction word (logged only)
i_rvfi_trap  in  1  instruction trapped
i_rvfi_halt  in  1  last instruction before halt
i_rvfi_intr  in  1  first instruction of a trap handler
i_rvfi_rs1_addr  in  5  rs1 index
i_rvfi_rs2_addr  in  5  rs2 index
i_rvfi_rs1_rdata  in  XLEN  rs1 value read
i_rvfi_rs2_rdata  in  XLEN  rs2 value read
i_rvfi_rd_addr  in  5  rd index (0 = no write)
i_rvfi_rd_wdata  in  XLEN  rd value written
i_rvfi_pc_rdata  in  XLEN  PC of this instruction
i_rvfi_pc_wdata  in  XLEN  next PC
o_err  out  1  sticky violation flag
o_err_code  out  3  first violation code
o_err_order  out  64  i_rvfi_order of the offending retire
o_retired  out  32  count of accepted retires, wraps at 2^32
o_halted  out  1  halt retire seen

Behaviour:
- Reset state:
  - Single clock i_clk; asynchronous active-low reset i_rst_n.
  - Reset clears all outputs to 0, exp_order to 0, pc_known to 0 and the shadow valid bitmap (31 bits) to 0.
  - Shadow data is not reset.
  - Reset asserted mid-stream discards all state; checking restarts at order 0.
- Idle and frozen conditions:
  - A cycle with i_rvfi_valid=0 changes no state.
  - Once o_err=1, all state is frozen until reset.
- Checks: for a valid retire while o_err=0, evaluate all checks in parallel against pre-update state. The lowest-numbered failing check wins.
  - 1 ORDER: i_rvfi_order != exp_order.
  - 2 PC: pc_known && !i_rvfi_intr && i_rvfi_pc_rdata != exp_pc.
  - 3 X0: i_rvfi_rd_addr==0 && i_rvfi_rd_wdata != 0.
  - 4 RS1: either of:
    - i_rvfi_rs1_addr==0 && i_rvfi_rs1_rdata != 0
    - addr!=0 && valid[addr] && i_rvfi_rs1_rdata != shadow[addr]
  - 5 RS2: same as RS1, using the rs2 fields.
  - 6 ALIGN: !i_rvfi_trap && next-PC misaligned:
    - C_EXT=0: pc_wdata[1:0] != 0
    - C_EXT=1: pc_wdata[0] != 0
  - 7 POSTHALT: o_halted=1 and any valid retire arrives.
  - The X0 rd_wdata check applies even when rd_addr==0.
  - An rs read of a register whose valid bit is clear passes; the first observed value is not captured from reads.
- On failure (registered, so visible the cycle after the offending retire):
  - o_err<=1
  - o_err_code<=code
  - o_err_order<=i_rvfi_order
  - no other state updates
- On pass, in the same clock edge:
  - exp_order<=order+1
  - exp_pc<=pc_wdata
  - pc_known<=1
  - o_retired<=o_retired+1
  - if rd_addr!=0: shadow[rd]<=rd_wdata, valid[rd]<=1
  - if i_rvfi_halt: o_halted<=1
- Trap retires:
  - Update order and exp_pc like any other retire.
  - The rd write is applied only if rd_addr!=0.
- Same-cycle read/write of the same register:
  - The rs comparison uses the old shadow value (NRET=1 semantics).
  - The write then takes effect.
- exp_order is 64-bit and wraps without error.

Test Plan:
- Reset, then 4 sequential retires:
  - orders 0..3, pc 0x0,0x4,0x8,0xC, pc_wdata = pc+4
  - required: o_retired=4, o_err=0.
- Order skip: retire order 0 then order 2 -> cycle after second retire o_err=1, o_err_code=1, o_err_order=2.
- PC discontinuity:
  - retire pc 0x0 → pc_wdata 0x100, then retire pc_rdata 0x104 -> o_err_code=2.
  - Same sequence with i_rvfi_intr=1 on the second retire -> no error.
- Shadow mismatch:
  - retire with rd=5, wdata=0xDEADBEEF
  - then retire with rs1=5, rs1_rdata=0xDEADBEEE -> o_err_code=4.
  - With CHECK_REGS=0 -> no error.
- Simultaneous faults: one retire with rd_addr=0, rd_wdata=1 and pc_wdata=0x102 (C_EXT=0) -> o_err_code=3 (priority over 6); following valid retires leave o_retired unchanged.
- Halt and reset:
  - retire with i_rvfi_halt=1 -> o_halted=1.
  - next valid retire -> o_err_code=7.
  - assert i_rst_n=0 mid-cycle -> all outputs 0 immediately.
